// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (0),
// LSU (1) and MULDIV (2) writeback outputs. At most one request is granted per
// cycle; the winning write is presented on registered rf_wr_* outputs one cycle
// later. Writes to x0 complete their handshake but issue no register-file write.
module reg_wr_arbiter #(
  parameter int unsigned num_req       = 3,
  parameter int unsigned data_width    = 32,
  parameter int unsigned reg_sel_width = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_req-1:0]               req_valid,
  input  logic [num_req*reg_sel_width-1:0] req_sel,
  input  logic [num_req*data_width-1:0]    req_data,
  output logic [num_req-1:0]               req_ready,
  output logic                             rf_wr_req,
  output logic [reg_sel_width-1:0]         rf_wr_sel,
  output logic [data_width-1:0]            rf_wr_data,
  output logic [$clog2(num_req)-1:0]       grant_id
);

  localparam int unsigned ptr_width = $clog2(num_req);

  typedef logic [ptr_width-1:0] ptr_t;

  ptr_t                     rr_ptr_q, rr_ptr_d;
  ptr_t                     win_idx;
  logic                     win_valid;
  logic [reg_sel_width-1:0] win_sel;
  logic [data_width-1:0]    win_data;

  // Scan requesters starting at rr_ptr and pick the first valid one.
  always_comb begin
    int unsigned idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < num_req; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (!win_valid && req_valid[idx]) begin
        win_valid = 1'b1;
        win_idx   = ptr_t'(idx);
      end
    end
  end

  // One-hot grant; depends only on req_valid and rr_ptr.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      req_ready[i] = win_valid && (win_idx == ptr_t'(i));
    end
  end

  // Select the winner's destination and data; only feeds the output registers.
  always_comb begin
    win_sel  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      if (req_ready[i]) begin
        win_sel  = req_sel[i*reg_sel_width +: reg_sel_width];
        win_data = req_data[i*data_width +: data_width];
      end
    end
  end

  // Advance priority to the requester just after the winner, wrapping to 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_valid) begin
      rr_ptr_d = (win_idx == ptr_t'(num_req - 1)) ? '0 : win_idx + ptr_t'(1);
    end
  end

  // Write-port and pointer registers; idle cycles hold everything but rf_wr_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_wr_req  <= 1'b0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
      grant_id   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      // x0 writes are consumed but never reach the register file.
      rf_wr_req <= win_valid && (win_sel != '0);
      if (win_valid) begin
        rf_wr_sel  <= win_sel;
        rf_wr_data <= win_data;
        grant_id   <= win_idx;
      end
    end
  end

endmodule
